fu_result_arbiter: RTL and testbench
====================================

// Module: fu_result_arbiter
// PURPOSE
// - Completion-side consumer of the pipelined functional units (mult, ALU, ...): drains FU results onto a single CDB.
// - Generates the per-FU stall back-pressure that the FUs obey.
// - Per-FU 2-entry result queues; round-robin grant among them; branch-mask squash/clear applied to every buffered result.
// - Sits between FU outputs and the CDB/ROB/RS wakeup logic.
// PARAMETERS
// N_FU    4   number of FU result ports
// TAG_W   6   physical-register tag width
// DATA_W  32  result data width
// BR_W    4   branch-mask width (one bit per in-flight branch)
// PORTS
// clock             in   1             system clock, rising edge
// reset             in   1             synchronous, active-high
// fu_valid          in   N_FU          FU i presents a result this cycle
// fu_tag            in   N_FU*TAG_W    destination tag, slice i
// fu_data           in   N_FU*DATA_W   result value, slice i
// fu_br_mask        in   N_FU*BR_W     branch dependencies of result i
// fu_stall          out  N_FU          FU i must hold its output; result not accepted
// br_valid          in   1             branch resolution event this cycle
// br_squash         in   1             1 = mispredict (squash), 0 = correct (clear)
// br_id             in   BR_W          one-hot id of the resolving branch
// cdb_valid         out  1             CDB broadcast valid
// cdb_tag           out  TAG_W         broadcast tag
// cdb_data          out  DATA_W        broadcast value
// cdb_fu_idx        out  $clog2(N_FU)  source FU of the broadcast
// BEHAVIOUR
// - Reset: all queues empty, RR pointer = 0, fu_stall = 0, cdb_valid = 0, cdb_tag/data/fu_idx = 0.
// - Reset asserted mid-operation discards all buffered results; no broadcast in the cycle after reset.
// - fu_stall[i] = (count[i] == 2), from registered state only; never a combinational function of fu_valid.
// - Accept rule: result enqueued at the clock edge iff fu_valid[i] && !fu_stall[i].
//   fu_valid while stalled is ignored; the FU holds its data.
// - Queue per FU: 2 entries, FIFO order, each entry {tag, data, br_mask}.
// - Arbitration, each cycle:
//   - Candidates = non-empty queues after the squash filter.
//   - Winner = first candidate at or after RR pointer, wrapping modulo N_FU.
//   - Winner's head is dequeued and loaded into the CDB output register.
//   - Pointer <= winner+1 (mod N_FU); pointer unchanged if there are no candidates.
// - Latency: result accepted at end of cycle c -> earliest cdb_valid in cycle c+2.
// - Throughput: one broadcast per cycle.
// - Same-edge enqueue and dequeue on a full queue is allowed. Stall is still registered, so a full queue stalls for >=1 cycle.
// - cdb_valid deasserts the cycle after no candidate wins. cdb_tag/data hold their last value when invalid.
// - Branch event, br_valid && br_squash:
//   - Drop every queued entry with (br_mask & br_id) != 0; survivors compact toward the head, order kept.
//   - An incoming fu result with a matching mask is not enqueued.
//   - A matching entry cannot win this cycle.
//   - If the CDB register currently holds a matching result, cdb_valid is cleared next cycle unless a new winner loads.
// - Branch event, br_valid && !br_squash: clear the br_id bit in all queued masks, in the incoming mask at enqueue, and in the CDB register mask.
// - br_id with zero bits set is a no-op. More than one bit set is illegal (assert in sim).
// - Squash and enqueue to the same queue on the same edge: filter first, then enqueue. Count never exceeds 2.
// CONFIGURATION
// - CDB_BYPASS_EN defined:
//   - An FU whose queue is empty and which is not stalled competes in arbitration with its live input in the same cycle (subject to the squash filter).
//   - If it wins, the result goes straight into the CDB register and is not enqueued. Latency c -> c+1.
// - CDB_BYPASS_EN undefined: every result passes through its queue; minimum latency is 2 cycles.
// - Pointer, stall and squash rules are identical in both builds.
// TESTING
// - Single result, no bypass:
//   - Stimulus: reset, then fu_valid[2]=1 tag=5 data=0xDEAD for 1 cycle at c.
//   - Response: cdb_valid=1 tag=5 data=0xDEAD fu_idx=2 in cycle c+2 only. With CDB_BYPASS_EN: cycle c+1.
// - Round-robin fairness:
//   - Stimulus: all 4 FUs continuously valid, distinct tags.
//   - Response: cdb_fu_idx sequence 0,1,2,3,0,...; no FU starves.
// - Back-pressure:
//   - Stimulus: FU1 valid for 4 cycles while FUs 0,2,3 keep winning.
//   - Response: fu_stall[1]=1 once its queue holds 2; no result lost or duplicated; 4 tags broadcast in order.
// - Squash:
//   - Stimulus: FU0 queue holds masks 0001, 0010; br_valid=1 br_squash=1 br_id=0001.
//   - Response: only the 0010 entry is ever broadcast.
//   - Stimulus: matching incoming result in the same cycle.
//   - Response: it is never broadcast.
// - Clear:
//   - Stimulus: queued mask 0011; br_valid=1 br_squash=0 br_id=0010; then squash id=0010.
//   - Response: the entry survives (mask 0001) and is broadcast.
// - Reset mid-stream:
//   - Stimulus: queues partly full, cdb_valid=1, assert reset for 1 cycle.
//   - Response: cdb_valid=0 and fu_stall=0 the next cycle; no stale tag ever broadcast.

Source files
------------

// File: rtl/fu_result_arbiter.sv
// fu_result_arbiter: 2-deep result queue per FU, round-robin drain onto one CDB.
// Define CDB_BYPASS_EN to let an idle FU's live result win in its own cycle.
module fu_result_arbiter #(
    parameter int N_FU   = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int BR_W   = 4,
    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_FU-1:0]        fu_valid,
    input  logic [N_FU*TAG_W-1:0]  fu_tag,
    input  logic [N_FU*DATA_W-1:0] fu_data,
    input  logic [N_FU*BR_W-1:0]   fu_br_mask,
    output logic [N_FU-1:0]        fu_stall,
    input  logic                   br_valid,
    input  logic                   br_squash,
    input  logic [BR_W-1:0]        br_id,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [DATA_W-1:0]      cdb_data,
    output logic [IDX_W-1:0]       cdb_fu_idx
);

    logic [1:0]        cnt_q  [N_FU];
    logic [1:0]        cnt_d  [N_FU];
    logic [TAG_W-1:0]  tag_q  [N_FU][2];
    logic [TAG_W-1:0]  tag_d  [N_FU][2];
    logic [DATA_W-1:0] data_q [N_FU][2];
    logic [DATA_W-1:0] data_d [N_FU][2];
    logic [BR_W-1:0]   mask_q [N_FU][2];
    logic [BR_W-1:0]   mask_d [N_FU][2];
    logic [IDX_W-1:0]  rr_q, rr_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [IDX_W-1:0]  cdb_idx_q, cdb_idx_d;

    logic              sq;
    logic [BR_W-1:0]   clr_bits;
    logic [N_FU-1:0]   live0, live1;
    logic [1:0]        f_cnt  [N_FU];
    logic [TAG_W-1:0]  f_tag  [N_FU][2];
    logic [DATA_W-1:0] f_data [N_FU][2];
    logic [BR_W-1:0]   f_mask [N_FU][2];
    logic [TAG_W-1:0]  in_tag  [N_FU];
    logic [DATA_W-1:0] in_data [N_FU];
    logic [BR_W-1:0]   in_mask [N_FU];
    logic [N_FU-1:0]   acc, byp, cand, deq, enq;
    logic [1:0]        c1 [N_FU];
    logic              found;
    logic [IDX_W-1:0]  win;
    int                arb_j;

    assign sq         = br_valid && br_squash;
    assign clr_bits   = (br_valid && !br_squash) ? br_id : '0;
    assign cdb_valid  = cdb_valid_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_data   = cdb_data_q;
    assign cdb_fu_idx = cdb_idx_q;

    // Stall depends only on registered occupancy
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            fu_stall[i] = (cnt_q[i] == 2'd2);
        end
    end

    // Squash filter with compaction, mask clear, and per-FU accept/candidacy
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            live0[i] = (cnt_q[i] != 2'd0) && !(sq && |(mask_q[i][0] & br_id));
            live1[i] = (cnt_q[i] == 2'd2) && !(sq && |(mask_q[i][1] & br_id));
            f_cnt[i] = {1'b0, live0[i]} + {1'b0, live1[i]};
            f_tag[i][0]  = live0[i] ? tag_q[i][0] : tag_q[i][1];
            f_data[i][0] = live0[i] ? data_q[i][0] : data_q[i][1];
            f_mask[i][0] = (live0[i] ? mask_q[i][0] : mask_q[i][1]) & ~clr_bits;
            f_tag[i][1]  = tag_q[i][1];
            f_data[i][1] = data_q[i][1];
            f_mask[i][1] = mask_q[i][1] & ~clr_bits;
            in_tag[i]  = fu_tag[i*TAG_W +: TAG_W];
            in_data[i] = fu_data[i*DATA_W +: DATA_W];
            in_mask[i] = fu_br_mask[i*BR_W +: BR_W] & ~clr_bits;
            acc[i] = fu_valid[i] && !fu_stall[i]
                     && !(sq && |(fu_br_mask[i*BR_W +: BR_W] & br_id));
`ifdef CDB_BYPASS_EN
            byp[i] = (f_cnt[i] == 2'd0) && acc[i];
`else
            byp[i] = 1'b0;
`endif
            cand[i] = (f_cnt[i] != 2'd0) || byp[i];
        end
    end

    // Round-robin pick starting at the pointer; load the CDB register
    always_comb begin
        found = 1'b0;
        win   = '0;
        arb_j = 0;
        for (int k = 0; k < N_FU; k++) begin
            arb_j = (int'(rr_q) + k) % N_FU;
            if (!found && cand[arb_j]) begin
                found = 1'b1;
                win   = IDX_W'(arb_j);
            end
        end
        cdb_valid_d = found;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_idx_d   = cdb_idx_q;
        rr_d        = rr_q;
        if (found) begin
            cdb_tag_d  = byp[win] ? in_tag[win]  : f_tag[win][0];
            cdb_data_d = byp[win] ? in_data[win] : f_data[win][0];
            cdb_idx_d  = win;
            rr_d       = IDX_W'((int'(win) + 1) % N_FU);
        end
    end

    // Queue next state: pop winner head, then append accepted input
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            deq[i] = found && (win == IDX_W'(i)) && !byp[i];
            enq[i] = acc[i] && !(found && (win == IDX_W'(i)) && byp[i]);
            c1[i]  = f_cnt[i] - {1'b0, deq[i]};
            tag_d[i][0]  = deq[i] ? f_tag[i][1]  : f_tag[i][0];
            data_d[i][0] = deq[i] ? f_data[i][1] : f_data[i][0];
            mask_d[i][0] = deq[i] ? f_mask[i][1] : f_mask[i][0];
            tag_d[i][1]  = f_tag[i][1];
            data_d[i][1] = f_data[i][1];
            mask_d[i][1] = f_mask[i][1];
            if (enq[i]) begin
                if (c1[i] == 2'd0) begin
                    tag_d[i][0]  = in_tag[i];
                    data_d[i][0] = in_data[i];
                    mask_d[i][0] = in_mask[i];
                end else begin
                    tag_d[i][1]  = in_tag[i];
                    data_d[i][1] = in_data[i];
                    mask_d[i][1] = in_mask[i];
                end
            end
            cnt_d[i] = c1[i] + {1'b0, enq[i]};
        end
    end

    // Queues, RR pointer and CDB register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_FU; i++) begin
                cnt_q[i] <= 2'd0;
                for (int s = 0; s < 2; s++) begin
                    tag_q[i][s]  <= '0;
                    data_q[i][s] <= '0;
                    mask_q[i][s] <= '0;
                end
            end
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_idx_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_idx_q   <= cdb_idx_d;
        end
    end

    // A resolving branch id must be one-hot or empty
    always @(posedge clock) begin
        if (!reset && br_valid) begin
            assert ($onehot0(br_id));
        end
    end

endmodule

// File: tb/tb_fu_result_arbiter.sv
// tb_fu_result_arbiter: directed and random stimulus for fu_result_arbiter
// against a queue-based reference model.
module tb_fu_result_arbiter;
    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int BW = 4;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  fu_valid;
    logic [N*TW-1:0] fu_tag;
    logic [N*DW-1:0] fu_data;
    logic [N*BW-1:0] fu_br_mask;
    logic [N-1:0]  fu_stall;
    logic          br_valid, br_squash;
    logic [BW-1:0] br_id;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [1:0]    cdb_fu_idx;

    always #5 clock = ~clock;

    fu_result_arbiter dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
        .fu_br_mask(fu_br_mask), .fu_stall(fu_stall),
        .br_valid(br_valid), .br_squash(br_squash), .br_id(br_id),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_fu_idx(cdb_fu_idx)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [BW-1:0] m;
    } ent_t;

    ent_t          mq [N][$];
    logic          m_cv;
    logic [TW-1:0] m_ct;
    logic [DW-1:0] m_cd;
    logic [1:0]    m_ci;
    int            m_rr;
    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] seen [$];
    logic [1:0]    seen_idx [$];

    task automatic chk(input string tg, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tg, obs, exp, $time);
        end
    endtask

    // Reference: one clock edge expressed with whole-queue operations
    task automatic model_update();
        bit       sq, cl;
        bit [N-1:0] st, acc;
        ent_t     inc [N];
        ent_t     nq [$];
        ent_t     e;
        int       w;
        if (reset) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_cv = 0; m_ct = '0; m_cd = '0; m_ci = '0;
            return;
        end
        sq = br_valid && br_squash;
        cl = br_valid && !br_squash;
        for (int i = 0; i < N; i++) begin
            st[i] = (mq[i].size() == 2);
            nq.delete();
            for (int k = 0; k < mq[i].size(); k++) begin
                e = mq[i][k];
                if (sq && ((e.m & br_id) != 0)) continue;
                if (cl) e.m = e.m & ~br_id;
                nq.push_back(e);
            end
            mq[i] = nq;
            inc[i].tag  = fu_tag[i*TW +: TW];
            inc[i].data = fu_data[i*DW +: DW];
            inc[i].m    = fu_br_mask[i*BW +: BW];
            acc[i] = fu_valid[i] && !st[i] && !(sq && ((inc[i].m & br_id) != 0));
            if (cl) inc[i].m = inc[i].m & ~br_id;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (w < 0 && (mq[j].size() > 0 || (BYP && acc[j]))) w = j;
        end
        if (w >= 0) begin
            if (mq[w].size() > 0) begin
                e = mq[w].pop_front();
            end else begin
                e = inc[w];
                acc[w] = 1'b0;
            end
            m_cv = 1'b1; m_ct = e.tag; m_cd = e.data; m_ci = w[1:0];
            m_rr = (w + 1) % N;
        end else begin
            m_cv = 1'b0;
        end
        for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(inc[i]);
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        @(negedge clock);
        chk("cdb_valid", cdb_valid, m_cv);
        chk("cdb_tag", cdb_tag, m_ct);
        chk("cdb_data", cdb_data, m_cd);
        chk("cdb_fu_idx", cdb_fu_idx, m_ci);
        for (int i = 0; i < N; i++) chk("fu_stall", fu_stall[i], mq[i].size() == 2);
        if (cdb_valid) begin
            seen.push_back(cdb_tag);
            seen_idx.push_back(cdb_fu_idx);
        end
    endtask

    task automatic idle();
        fu_valid = '0; fu_tag = '0; fu_data = '0; fu_br_mask = '0;
        br_valid = 1'b0; br_squash = 1'b0; br_id = '0;
    endtask

    task automatic drive_fu(input int i, input logic [TW-1:0] t,
                            input logic [DW-1:0] d, input logic [BW-1:0] m);
        fu_valid[i] = 1'b1;
        fu_tag[i*TW +: TW] = t;
        fu_data[i*DW +: DW] = d;
        fu_br_mask[i*BW +: BW] = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    function automatic int count_tag(input logic [TW-1:0] t);
        int n = 0;
        foreach (seen[k]) if (seen[k] == t) n++;
        return n;
    endfunction

    initial begin
        idle();
        do_reset();
        chk("reset_valid", cdb_valid, 0);
        chk("reset_stall", fu_stall, 0);
        chk("reset_tag", cdb_tag, 0);

        // single result on FU2
        drive_fu(2, 6'd5, 32'hDEAD, '0);
        step();
        idle();
        chk("single_c1_valid", cdb_valid, BYP);
        if (BYP) chk("single_c1_tag", cdb_tag, 5);
        step();
        chk("single_c2_valid", cdb_valid, !BYP);
        if (!BYP) begin
            chk("single_c2_tag", cdb_tag, 5);
            chk("single_c2_data", cdb_data, 32'hDEAD);
            chk("single_c2_idx", cdb_fu_idx, 2);
        end
        step();
        chk("single_done", cdb_valid, 0);

        // round-robin with every FU continuously valid
        do_reset();
        seen.delete(); seen_idx.delete();
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(fu_valid[i] && mq[i].size() == 2)) begin
                    logic [3:0] cc;
                    logic [1:0] ii;
                    cc = c[3:0]; ii = i[1:0];
                    drive_fu(i, {ii, cc}, 32'h1000 * i + c, '0);
                end
            end
            step();
        end
        idle();
        chk("rr_count", seen_idx.size() >= 8, 1);
        for (int k = 0; k < 8 && k < seen_idx.size(); k++)
            chk("rr_idx", seen_idx[k], k % 4);

        // queued squash keeps only the surviving branch path
        do_reset();
        seen.delete();
        drive_fu(0, 6'd20, 32'h20, 4'b0001);
        step();
        idle();
        drive_fu(0, 6'd21, 32'h21, 4'b0010);
        br_valid = 1'b1; br_squash = 1'b1; br_id = 4'b0001;
        step();
        idle();
        repeat (3) step();
        chk("sq_keep", count_tag(6'd21), 1);
        chk("sq_drop", count_tag(6'd20), BYP);

        // incoming result squashed on the same edge
        seen.delete();
        drive_fu(0, 6'd10, 32'h10, 4'b0001);
        br_valid = 1'b1; br_squash = 1'b1; br_id = 4'b0001;
        step();
        idle();
        repeat (3) step();
        chk("sq_incoming", count_tag(6'd10), 0);

        // clear then squash on the cleared bit
        seen.delete();
        drive_fu(0, 6'd12, 32'h12, 4'b0011);
        br_valid = 1'b1; br_squash = 1'b0; br_id = 4'b0010;
        step();
        idle();
        br_valid = 1'b1; br_squash = 1'b1; br_id = 4'b0010;
        step();
        idle();
        repeat (3) step();
        chk("clear_survive", count_tag(6'd12), 1);

        // reset mid-stream
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) drive_fu(i, 6'(40 + 4 * c + i), 32'h40 + c, '0);
            step();
        end
        reset = 1'b1;
        step();
        chk("rst_mid_valid", cdb_valid, 0);
        chk("rst_mid_stall", fu_stall, 0);
        reset = 1'b0;
        idle();
        seen.delete();
        repeat (3) step();
        chk("rst_mid_stale", seen.size(), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (fu_valid[i] && mq[i].size() == 2) begin
                    // held by stall
                end else if ($urandom_range(0, 1) == 1) begin
                    drive_fu(i, TW'($urandom), $urandom, BW'($urandom & $urandom));
                end else begin
                    fu_valid[i] = 1'b0;
                end
            end
            br_valid = 1'b0; br_squash = 1'b0; br_id = '0;
            if ($urandom_range(0, 3) == 0) begin
                int b;
                b = $urandom_range(0, 4);
                br_valid  = 1'b1;
                br_squash = $urandom_range(0, 1);
                br_id     = (b == 4) ? '0 : BW'(1 << b);
            end
            step();
        end
        reset = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
